// File: rtl/alu_panel_seq_pkg.sv
// Shared types and switch-field layout for the ALU front-panel sequencer.
package alu_panel_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // sw = {opcode, addr_c, addr_b, addr_a}; each index is scaled by the address width
    localparam int unsigned SW_FIELD_A   = 0;
    localparam int unsigned SW_FIELD_B   = 1;
    localparam int unsigned SW_FIELD_C   = 2;
    localparam int unsigned SW_FIELD_OPC = 3;

    function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned addr_w);
        return idx * addr_w;
    endfunction

endpackage

// File: rtl/alu_panel_seq_key_conditioner.sv
// Synchronises, debounces and edge-detects one active-low push button.
module key_conditioner #(
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Level follows the synchronised key only after DEB_CYCLES consecutive differing samples
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = level_q & ~level_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/alu_panel_seq.sv
// Front-panel sequencer: turns debounced key presses into single ALU instructions
// and captures the core result for display.
module alu_panel_seq
    import alu_panel_seq_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned OPC_W      = 4,
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [OPC_W+3*ADDR_W-1:0] sw,
    input  logic                      key_exec_n,
    input  logic                      key_view_n,
    input  logic                      ready,
    input  logic                      wen,
    input  logic [DATA_W-1:0]         res,
    output logic                      start,
    output logic [OPC_W-1:0]          opcode,
    output logic [ADDR_W-1:0]         addr_a,
    output logic [ADDR_W-1:0]         addr_b,
    output logic [ADDR_W-1:0]         addr_c,
    output logic [DATA_W-1:0]         result_q,
    output logic                      busy,
    output logic                      blank_res,
    output logic                      blank_view,
    output logic                      err_drop,
    output logic                      err_timeout
);

    localparam int unsigned A_LSB   = field_lsb(SW_FIELD_A, ADDR_W);
    localparam int unsigned B_LSB   = field_lsb(SW_FIELD_B, ADDR_W);
    localparam int unsigned C_LSB   = field_lsb(SW_FIELD_C, ADDR_W);
    localparam int unsigned OPC_LSB = field_lsb(SW_FIELD_OPC, ADDR_W);
    localparam int unsigned TMR_W   = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic                exec_press, view_press;
    logic                exec_ok, view_ok, timer_expired;
    logic                start_q, start_d, busy_q, busy_d;
    logic                err_drop_q, err_drop_d, err_timeout_q, err_timeout_d;
    logic                blank_res_q, blank_res_d, blank_view_q, blank_view_d;
    logic [OPC_W-1:0]    opcode_q, opcode_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
    logic [DATA_W-1:0]   result_r_q, result_r_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_key_exec (
        .clk   (CLK),
        .rst   (RST),
        .key_n (key_exec_n),
        .press (exec_press)
    );

    key_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_key_view (
        .clk   (CLK),
        .rst   (RST),
        .key_n (key_view_n),
        .press (view_press)
    );

    // Coincident presses cancel each other
    assign exec_ok       = exec_press & ~view_press;
    assign view_ok       = view_press & ~exec_press;
    assign timer_expired = (timer_q == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (exec_ok && ready) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (wen)                state_d = ST_DONE;
                else if (timer_expired) state_d = ST_IDLE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are derived from the next state so the registered copies line up with state_q
    always_comb begin
        opcode_d      = opcode_q;
        addr_a_d      = addr_a_q;
        addr_b_d      = addr_b_q;
        addr_c_d      = addr_c_q;
        result_r_d    = result_r_q;
        blank_res_d   = blank_res_q;
        blank_view_d  = blank_view_q;
        err_timeout_d = err_timeout_q;
        timer_d       = '0;
        start_d       = (state_d == ST_ISSUE);
        busy_d        = (state_d != ST_IDLE);
        err_drop_d    = exec_ok && ((state_q != ST_IDLE) || !ready);
        case (state_q)
            ST_IDLE: begin
                if (exec_ok && ready) begin
                    opcode_d      = sw[OPC_LSB +: OPC_W];
                    addr_c_d      = sw[C_LSB +: ADDR_W];
                    addr_b_d      = sw[B_LSB +: ADDR_W];
                    addr_a_d      = sw[A_LSB +: ADDR_W];
                    err_timeout_d = 1'b0;
                end else if (view_ok) begin
                    addr_b_d     = sw[B_LSB +: ADDR_W];
                    addr_a_d     = sw[A_LSB +: ADDR_W];
                    blank_view_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (wen) begin
                    result_r_d  = res;
                    blank_res_d = 1'b0;
                end else if (timer_expired) begin
                    err_timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            err_drop_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            blank_res_q   <= 1'b1;
            blank_view_q  <= 1'b1;
            opcode_q      <= '0;
            addr_a_q      <= '0;
            addr_b_q      <= '0;
            addr_c_q      <= '0;
            result_r_q    <= '0;
            timer_q       <= '0;
        end else begin
            start_q       <= start_d;
            busy_q        <= busy_d;
            err_drop_q    <= err_drop_d;
            err_timeout_q <= err_timeout_d;
            blank_res_q   <= blank_res_d;
            blank_view_q  <= blank_view_d;
            opcode_q      <= opcode_d;
            addr_a_q      <= addr_a_d;
            addr_b_q      <= addr_b_d;
            addr_c_q      <= addr_c_d;
            result_r_q    <= result_r_d;
            timer_q       <= timer_d;
        end
    end

    assign start       = start_q;
    assign busy        = busy_q;
    assign err_drop    = err_drop_q;
    assign err_timeout = err_timeout_q;
    assign blank_res   = blank_res_q;
    assign blank_view  = blank_view_q;
    assign opcode      = opcode_q;
    assign addr_a      = addr_a_q;
    assign addr_b      = addr_b_q;
    assign addr_c      = addr_c_q;
    assign result_q    = result_r_q;

endmodule

// File: tb/tb_alu_panel_seq.sv
// Randomised scenario bench for alu_panel_seq against a field-level reference model.
module tb_alu_panel_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] sw = '0;
    logic        key_exec_n = 1'b1, key_view_n = 1'b1;
    logic        ready = 1'b1, wen = 1'b0;
    logic [15:0] res = '0;
    logic        start, busy, blank_res, blank_view, err_drop, err_timeout;
    logic [3:0]  opcode, addr_a, addr_b, addr_c;
    logic [15:0] result_q;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;
    int drop_cnt  = 0;

    // Reference model: what the panel should be showing
    logic [3:0]  m_opc = '0, m_a = '0, m_b = '0, m_c = '0;
    logic [15:0] m_result = '0;
    logic        m_blank_res = 1'b1, m_blank_view = 1'b1, m_err_to = 1'b0;

    alu_panel_seq #(
        .DATA_W(16), .ADDR_W(4), .OPC_W(4), .DEB_CYCLES(4), .TIMEOUT(8)
    ) dut (
        .CLK(CLK), .RST(RST), .sw(sw), .key_exec_n(key_exec_n), .key_view_n(key_view_n),
        .ready(ready), .wen(wen), .res(res), .start(start), .opcode(opcode),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .result_q(result_q),
        .busy(busy), .blank_res(blank_res), .blank_view(blank_view),
        .err_drop(err_drop), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (start)    start_cnt++;
        if (err_drop) drop_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic void model_load_all(input logic [15:0] v);
        m_a   = 4'(v % 16);
        m_b   = 4'((v / 16) % 16);
        m_c   = 4'((v / 256) % 16);
        m_opc = 4'(v / 4096);
    endfunction

    task automatic test_reset();
        RST = 1'b1; key_exec_n = 1'b1; key_view_n = 1'b1; wen = 1'b0;
        tick(3);
        n_tests++; if (start !== 1'b0)       begin n_fail++; $display("FAIL reset_start got %b want 0", start); end
        n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (err_drop !== 1'b0)    begin n_fail++; $display("FAIL reset_err_drop got %b want 0", err_drop); end
        n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err_timeout got %b want 0", err_timeout); end
        n_tests++; if ({opcode, addr_c, addr_b, addr_a} !== 16'h0000)
            begin n_fail++; $display("FAIL reset_fields got %h want 0000", {opcode, addr_c, addr_b, addr_a}); end
        n_tests++; if (result_q !== 16'h0000) begin n_fail++; $display("FAIL reset_result got %h want 0000", result_q); end
        n_tests++; if ({blank_res, blank_view} !== 2'b11)
            begin n_fail++; $display("FAIL reset_blank got %b want 11", {blank_res, blank_view}); end
        RST = 1'b0;
        tick(2);
    endtask

    task automatic test_exec(input logic [15:0] sw_v, input logic [15:0] res_v);
        int base;
        base = start_cnt;
        ready = 1'b1; sw = sw_v;
        key_exec_n = 1'b0;
        tick(10);
        key_exec_n = 1'b1;
        model_load_all(sw_v);
        m_err_to = 1'b0;
        n_tests++; if (start_cnt - base != 1) begin n_fail++; $display("FAIL exec_start_pulses got %0d want 1", start_cnt - base); end
        n_tests++; if ({opcode, addr_c, addr_b, addr_a} !== {m_opc, m_c, m_b, m_a})
            begin n_fail++; $display("FAIL exec_fields got %h want %h", {opcode, addr_c, addr_b, addr_a}, {m_opc, m_c, m_b, m_a}); end
        n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL exec_err_timeout got %b want 0", err_timeout); end
        wen = 1'b1; res = res_v;
        tick(1);
        wen = 1'b0; res = 16'($urandom);
        m_result = res_v; m_blank_res = 1'b0;
        n_tests++; if (result_q !== m_result) begin n_fail++; $display("FAIL exec_result got %h want %h", result_q, m_result); end
        n_tests++; if (blank_res !== 1'b0)    begin n_fail++; $display("FAIL exec_blank_res got %b want 0", blank_res); end
        n_tests++; if (busy !== 1'b1)         begin n_fail++; $display("FAIL exec_done_busy got %b want 1", busy); end
        tick(1);
        n_tests++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL exec_idle_busy got %b want 0", busy); end
        tick(12);
    endtask

    task automatic test_view_idle(input logic [15:0] sw_v);
        sw = sw_v;
        key_view_n = 1'b0;
        tick(10);
        key_view_n = 1'b1;
        m_a = 4'(sw_v % 16); m_b = 4'((sw_v / 16) % 16); m_blank_view = 1'b0;
        n_tests++; if ({opcode, addr_c, addr_b, addr_a} !== {m_opc, m_c, m_b, m_a})
            begin n_fail++; $display("FAIL view_fields got %h want %h", {opcode, addr_c, addr_b, addr_a}, {m_opc, m_c, m_b, m_a}); end
        n_tests++; if (blank_view !== 1'b0) begin n_fail++; $display("FAIL view_blank got %b want 0", blank_view); end
        n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL view_busy got %b want 0", busy); end
        tick(12);
    endtask

    task automatic test_bounce();
        int s0, d0;
        s0 = start_cnt; d0 = drop_cnt;
        for (int i = 0; i < 20; i++) begin
            key_exec_n = i[0];
            tick(1);
        end
        key_exec_n = 1'b1;
        tick(12);
        n_tests++; if (start_cnt - s0 != 0) begin n_fail++; $display("FAIL bounce_start got %0d want 0", start_cnt - s0); end
        n_tests++; if (drop_cnt - d0 != 0)  begin n_fail++; $display("FAIL bounce_drop got %0d want 0", drop_cnt - d0); end
    endtask

    task automatic test_not_ready();
        int s0, d0;
        s0 = start_cnt; d0 = drop_cnt;
        ready = 1'b0; sw = 16'($urandom);
        key_exec_n = 1'b0;
        tick(10);
        key_exec_n = 1'b1;
        tick(12);
        ready = 1'b1;
        n_tests++; if (drop_cnt - d0 != 1)  begin n_fail++; $display("FAIL notready_drop got %0d want 1", drop_cnt - d0); end
        n_tests++; if (start_cnt - s0 != 0) begin n_fail++; $display("FAIL notready_start got %0d want 0", start_cnt - s0); end
        n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL notready_busy got %b want 0", busy); end
        n_tests++; if ({opcode, addr_c, addr_b, addr_a} !== {m_opc, m_c, m_b, m_a})
            begin n_fail++; $display("FAIL notready_fields got %h want %h", {opcode, addr_c, addr_b, addr_a}, {m_opc, m_c, m_b, m_a}); end
    endtask

    task automatic test_timeout();
        logic [15:0] v;
        int k;
        v = 16'($urandom);
        ready = 1'b1; sw = v;
        key_exec_n = 1'b0;
        tick(10);
        key_exec_n = 1'b1;
        model_load_all(v);
        k = 0;
        while (busy === 1'b1 && k < 30) begin tick(1); k++; end
        n_tests++; if (k >= 30) begin n_fail++; $display("FAIL timeout_wait busy still %b after %0d cycles", busy, k); end
        m_err_to = 1'b1;
        n_tests++; if (err_timeout !== m_err_to) begin n_fail++; $display("FAIL timeout_flag got %b want 1", err_timeout); end
        n_tests++; if (result_q !== m_result)    begin n_fail++; $display("FAIL timeout_result got %h want %h", result_q, m_result); end
        n_tests++; if (blank_res !== m_blank_res) begin n_fail++; $display("FAIL timeout_blank got %b want %b", blank_res, m_blank_res); end
        tick(12);
        n_tests++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b want 1", err_timeout); end
    endtask

    task automatic test_simultaneous();
        int s0, d0;
        s0 = start_cnt; d0 = drop_cnt;
        sw = 16'($urandom);
        key_exec_n = 1'b0; key_view_n = 1'b0;
        tick(10);
        key_exec_n = 1'b1; key_view_n = 1'b1;
        tick(12);
        n_tests++; if (start_cnt - s0 != 0) begin n_fail++; $display("FAIL simul_start got %0d want 0", start_cnt - s0); end
        n_tests++; if (drop_cnt - d0 != 0)  begin n_fail++; $display("FAIL simul_drop got %0d want 0", drop_cnt - d0); end
        n_tests++; if ({opcode, addr_c, addr_b, addr_a} !== {m_opc, m_c, m_b, m_a})
            begin n_fail++; $display("FAIL simul_fields got %h want %h", {opcode, addr_c, addr_b, addr_a}, {m_opc, m_c, m_b, m_a}); end
        n_tests++; if (blank_view !== m_blank_view) begin n_fail++; $display("FAIL simul_blank_view got %b want %b", blank_view, m_blank_view); end
    endtask

    task automatic test_view_busy();
        logic [15:0] v1, v2, r;
        int d0;
        v1 = 16'($urandom); v2 = ~v1; r = 16'($urandom);
        d0 = drop_cnt;
        ready = 1'b1; sw = v1;
        key_exec_n = 1'b0;
        tick(3);
        key_view_n = 1'b0;
        tick(5);
        sw = v2;
        tick(2);
        key_exec_n = 1'b1; key_view_n = 1'b1;
        model_load_all(v1);
        m_err_to = 1'b0;
        wen = 1'b1; res = r;
        tick(1);
        wen = 1'b0;
        m_result = r; m_blank_res = 1'b0;
        n_tests++; if ({addr_b, addr_a} !== {m_b, m_a})
            begin n_fail++; $display("FAIL viewbusy_ab got %h want %h", {addr_b, addr_a}, {m_b, m_a}); end
        n_tests++; if (result_q !== m_result) begin n_fail++; $display("FAIL viewbusy_result got %h want %h", result_q, m_result); end
        n_tests++; if (drop_cnt - d0 != 0)    begin n_fail++; $display("FAIL viewbusy_drop got %0d want 0", drop_cnt - d0); end
        tick(12);
    endtask

    task automatic test_reset_mid_wait();
        ready = 1'b1; sw = 16'($urandom);
        key_exec_n = 1'b0;
        tick(10);
        key_exec_n = 1'b1;
        RST = 1'b1;
        tick(1);
        RST = 1'b0; wen = 1'b1; res = 16'($urandom) | 16'h0001;
        tick(1);
        wen = 1'b0;
        m_opc = '0; m_a = '0; m_b = '0; m_c = '0;
        m_result = '0; m_blank_res = 1'b1; m_blank_view = 1'b1; m_err_to = 1'b0;
        n_tests++; if (result_q !== m_result)     begin n_fail++; $display("FAIL rstwait_result got %h want %h", result_q, m_result); end
        n_tests++; if (blank_res !== m_blank_res) begin n_fail++; $display("FAIL rstwait_blank_res got %b want 1", blank_res); end
        n_tests++; if (busy !== 1'b0)             begin n_fail++; $display("FAIL rstwait_busy got %b want 0", busy); end
        n_tests++; if (blank_view !== m_blank_view) begin n_fail++; $display("FAIL rstwait_blank_view got %b want 1", blank_view); end
        tick(10);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstwait_idle got busy %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_exec(16'h1321, 16'hBEEF);
        test_view_idle(16'($urandom));
        for (int i = 0; i < 3; i++) test_exec(16'($urandom), 16'($urandom));
        test_bounce();
        test_not_ready();
        test_timeout();
        test_exec(16'($urandom), 16'($urandom));
        test_simultaneous();
        test_view_busy();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
